// File: rtl/dg_pkt_gen_if.sv
// Command and packet-stream signals between the command-fetch stage, the
// packet generator and the cache input port.
interface dg_pkt_gen_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [3:0]        i_da;
    logic [2:0]        i_prior;
    logic [9:0]        i_len;
    logic              i_vld;
    logic              o_dg_ready;
    logic              o_vld;
    logic              o_sop;
    logic              o_eop;
    logic [DATA_W-1:0] o_data;
    logic              i_ready;

    modport master (
        input  i_da, i_prior, i_len, i_vld, i_ready,
        output o_dg_ready, o_vld, o_sop, o_eop, o_data
    );

    modport slave (
        output i_da, i_prior, i_len, i_vld, i_ready,
        input  o_dg_ready, o_vld, o_sop, o_eop, o_data
    );
endinterface

// File: rtl/dg_pkt_gen.sv
// Packet generator: turns one (da, prior, len) command into a header word plus
// len deterministic payload words, SOP/EOP framed, with downstream backpressure.
module dg_pkt_gen #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    dg_pkt_gen_if.master     bus,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic             o_drop_err
);
    localparam int unsigned LEN_W = 10;
    localparam int unsigned SEQ_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY} state_e;

    state_e             st_q, st_d;
    logic [3:0]         da_q, da_d;
    logic [2:0]         prior_q, prior_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               ready_q, ready_d;
    logic               vld_q, vld_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               accept;
    logic [LEN_W-1:0]   k_nxt;

    function automatic logic [31:0] head_word(logic [LEN_W-1:0] l, logic [2:0] p, logic [3:0] d);
        return {15'b0, l, p, d};
    endfunction

    function automatic logic [31:0] body_word(logic [SEQ_W-1:0] s, logic [3:0] d,
                                              logic [2:0] p, logic [LEN_W-1:0] k);
        return {s, d, 1'b0, p, 6'b0, k};
    endfunction

    assign accept = vld_q & bus.i_ready;
    assign k_nxt  = LEN_W'(k_q + LEN_W'(1));

    always_comb begin
        st_d    = st_q;
        da_d    = da_q;
        prior_d = prior_q;
        len_d   = len_q;
        seq_d   = seq_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        ready_d = ready_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;

        unique case (st_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.i_vld) begin
                    da_d    = bus.i_da;
                    prior_d = bus.i_prior;
                    len_d   = bus.i_len;
                    seq_d   = cnt_q[SEQ_W-1:0];
                    st_d    = ST_HEAD;
                    ready_d = 1'b0;
                    vld_d   = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = (bus.i_len == '0);
                    data_d  = DATA_W'(head_word(bus.i_len, bus.i_prior, bus.i_da));
                end
            end
            ST_HEAD: begin
                if (accept && !eop_q) begin
                    st_d   = ST_BODY;
                    k_d    = '0;
                    sop_d  = 1'b0;
                    eop_d  = (len_q == LEN_W'(1));
                    data_d = DATA_W'(body_word(seq_q, da_q, prior_q, '0));
                end
            end
            ST_BODY: begin
                if (accept && !eop_q) begin
                    k_d    = k_nxt;
                    eop_d  = (k_nxt == LEN_W'(len_q - LEN_W'(1)));
                    data_d = DATA_W'(body_word(seq_q, da_q, prior_q, k_nxt));
                end
            end
            default: st_d = ST_IDLE;
        endcase

        // EOP accepted: packet complete, return to idle and count it
        if (st_q != ST_IDLE && accept && eop_q) begin
            st_d    = ST_IDLE;
            ready_d = 1'b1;
            vld_d   = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
            cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
        end

        // A command while busy is discarded but remembered until reset
        if (st_q != ST_IDLE && bus.i_vld) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            da_q    <= '0;
            prior_q <= '0;
            len_q   <= '0;
            seq_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            ready_q <= 1'b0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            st_q    <= st_d;
            da_q    <= da_d;
            prior_q <= prior_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            ready_q <= ready_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_dg_ready = ready_q;
    assign bus.o_vld      = vld_q;
    assign bus.o_sop      = sop_q;
    assign bus.o_eop      = eop_q;
    assign bus.o_data     = data_q;
    assign o_pkt_cnt      = cnt_q;
    assign o_drop_err     = drop_q;
endmodule

// File: tb/tb_dg_pkt_gen.sv
// Directed bench for dg_pkt_gen: framing, payload pattern, backpressure,
// busy drop, counter/seq wrap, max length and asynchronous reset.
module tb_dg_pkt_gen;
    logic        clk;
    logic        rst;
    logic [15:0] o_pkt_cnt;
    logic        o_drop_err;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt;

    dg_pkt_gen_if #(.DATA_W(32)) bus ();

    dg_pkt_gen #(.DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_pkt_cnt  (o_pkt_cnt),
        .o_drop_err (o_drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(int idx, logic [3:0] d, logic [2:0] p,
                                             logic [9:0] ln, logic [7:0] s);
        logic [31:0] w;
        if (idx == 0) w = (32'(ln) << 7) | (32'(p) << 4) | 32'(d);
        else          w = (32'(s) << 24) | (32'(d) << 20) | (32'(p) << 16) | 32'(idx - 1);
        return w;
    endfunction

    // Issue one command strobe; returns at the negedge after it was sampled
    task automatic send_cmd(input logic [3:0] d, input logic [2:0] p, input logic [9:0] ln);
        bus.i_da    = d;
        bus.i_prior = p;
        bus.i_len   = ln;
        bus.i_vld   = 1'b1;
        @(negedge clk);
        bus.i_vld   = 1'b0;
    endtask

    // Receive and check every word of one packet, then the idle state after EOP
    task automatic recv_pkt(input logic [3:0] d, input logic [2:0] p, input logic [9:0] ln,
                            input logic [7:0] s, input bit bp, input int drop_at);
        int idx = 0;
        int guard = 0;
        bit dropped = 0;
        while (idx <= int'(ln) && guard < 20000) begin
            bus.i_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (idx == drop_at && !dropped) begin
                bus.i_vld   = 1'b1;
                bus.i_da    = 4'hA;
                bus.i_prior = 3'd1;
                bus.i_len   = 10'd5;
                dropped     = 1;
            end else begin
                bus.i_vld = 1'b0;
            end
            chk("vld",  64'(bus.o_vld), 64'(1));
            chk("data", 64'(bus.o_data), 64'(exp_word(idx, d, p, ln, s)));
            chk("sop",  64'(bus.o_sop), 64'(idx == 0));
            chk("eop",  64'(bus.o_eop), 64'(idx == int'(ln)));
            if (idx == 0) chk("busy_ready", 64'(bus.o_dg_ready), 64'(0));
            if (bus.i_ready) idx++;
            @(negedge clk);
            guard++;
        end
        bus.i_vld   = 1'b0;
        bus.i_ready = 1'b1;
        if (guard >= 20000) chk("timeout", 64'(guard), 64'(0));
        exp_cnt = exp_cnt + 16'd1;
        chk("post_vld",   64'(bus.o_vld), 64'(0));
        chk("post_ready", 64'(bus.o_dg_ready), 64'(1));
        chk("pkt_cnt",    64'(o_pkt_cnt), 64'(exp_cnt));
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_da    = '0;
        bus.i_prior = '0;
        bus.i_len   = '0;
        bus.i_vld   = 1'b0;
        bus.i_ready = 1'b1;
        exp_cnt     = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.o_dg_ready), 64'(0));
        chk("rst_vld",   64'(bus.o_vld), 64'(0));
        chk("rst_data",  64'(bus.o_data), 64'(0));
        chk("rst_cnt",   64'(o_pkt_cnt), 64'(0));
        chk("rst_drop",  64'(o_drop_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.o_dg_ready), 64'(1));

        // Single command with hand-computed words
        send_cmd(4'd5, 3'd3, 10'd2);
        chk("p1_h_data", 64'(bus.o_data), 64'h0000_0135);
        chk("p1_h_sop",  64'(bus.o_sop), 64'(1));
        chk("p1_h_eop",  64'(bus.o_eop), 64'(0));
        chk("p1_h_vld",  64'(bus.o_vld), 64'(1));
        chk("p1_ready",  64'(bus.o_dg_ready), 64'(0));
        @(negedge clk);
        chk("p1_w0_data", 64'(bus.o_data), 64'h0053_0000);
        chk("p1_w0_sop",  64'(bus.o_sop), 64'(0));
        chk("p1_w0_eop",  64'(bus.o_eop), 64'(0));
        @(negedge clk);
        chk("p1_w1_data", 64'(bus.o_data), 64'h0053_0001);
        chk("p1_w1_eop",  64'(bus.o_eop), 64'(1));
        @(negedge clk);
        exp_cnt = 16'd1;
        chk("p1_cnt",   64'(o_pkt_cnt), 64'(1));
        chk("p1_ready", 64'(bus.o_dg_ready), 64'(1));
        chk("p1_vld",   64'(bus.o_vld), 64'(0));
        chk("p1_drop",  64'(o_drop_err), 64'(0));

        // Zero length packet
        send_cmd(4'd15, 3'd7, 10'd0);
        chk("z_data", 64'(bus.o_data), 64'h0000_007F);
        chk("z_sop",  64'(bus.o_sop), 64'(1));
        chk("z_eop",  64'(bus.o_eop), 64'(1));
        @(negedge clk);
        exp_cnt = 16'd2;
        chk("z_cnt", 64'(o_pkt_cnt), 64'(2));
        chk("z_vld", 64'(bus.o_vld), 64'(0));

        // Backpressure
        send_cmd(4'd9, 3'd2, 10'd4);
        recv_pkt(4'd9, 3'd2, 10'd4, 8'(exp_cnt), 1'b1, -1);

        // Command while busy
        send_cmd(4'd3, 3'd6, 10'd10);
        recv_pkt(4'd3, 3'd6, 10'd10, 8'(exp_cnt), 1'b0, 3);
        chk("drop_set", 64'(o_drop_err), 64'(1));

        // Counter and seq wrap: seq tracks the counter's low byte through 256
        for (int i = 0; i < 257; i++) begin
            send_cmd(4'(i), 3'(i), 10'(i % 3));
            recv_pkt(4'(i), 3'(i), 10'(i % 3), 8'(exp_cnt), 1'b0, -1);
        end
        chk("drop_sticky", 64'(o_drop_err), 64'(1));

        // Maximum length
        send_cmd(4'd6, 3'd5, 10'd1023);
        recv_pkt(4'd6, 3'd5, 10'd1023, 8'(exp_cnt), 1'b0, -1);

        // Asynchronous reset mid-packet
        send_cmd(4'd2, 3'd4, 10'd10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_vld", 64'(bus.o_vld), 64'(1));
        rst = 1'b1;
        #1;
        chk("arst_vld",   64'(bus.o_vld), 64'(0));
        chk("arst_sop",   64'(bus.o_sop), 64'(0));
        chk("arst_eop",   64'(bus.o_eop), 64'(0));
        chk("arst_data",  64'(bus.o_data), 64'(0));
        chk("arst_ready", 64'(bus.o_dg_ready), 64'(0));
        chk("arst_cnt",   64'(o_pkt_cnt), 64'(0));
        chk("arst_drop",  64'(o_drop_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("arst_ready_held", 64'(bus.o_dg_ready), 64'(0));
        @(negedge clk);
        chk("arst_ready_rise", 64'(bus.o_dg_ready), 64'(1));
        exp_cnt = '0;
        send_cmd(4'd1, 3'd2, 10'd2);
        recv_pkt(4'd1, 3'd2, 10'd2, 8'h00, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
